// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_pkg;

   // Arbiter sequencing: waiting for a request, holding operands, presenting a result
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CNTRL_W    = 3;
   localparam int FLAG_W     = 4;
   localparam int WAIT_CNT_W = 8;

   // Bit positions inside the {negative, zero, overflow, carry_out} flag vector
   localparam int FLAG_CARRY = 0;
   localparam int FLAG_OVF   = 1;
   localparam int FLAG_ZERO  = 2;
   localparam int FLAG_NEG   = 3;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side request/response bundle for two clients sharing one ALU.
interface alu_arbiter_if #(
   parameter int DATA_WIDTH = 64
);
   import alu_pkg::*;

   logic [1:0]                 req_valid;
   logic [1:0]                 req_ready;
   logic [1:0][DATA_WIDTH-1:0] req_A;
   logic [1:0][DATA_WIDTH-1:0] req_B;
   logic [1:0][CNTRL_W-1:0]    req_cntrl;
   logic [1:0]                 resp_valid;
   logic [1:0]                 resp_ready;
   logic [DATA_WIDTH-1:0]      resp_result;
   logic [FLAG_W-1:0]          resp_flags;

   // Arbiter side
   modport slave (
      input  req_valid, req_A, req_B, req_cntrl, resp_ready,
      output req_ready, resp_valid, resp_result, resp_flags
   );

   // Requester side
   modport master (
      output req_valid, req_A, req_B, req_cntrl, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_flags
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a contended request goes to the side not served last.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   // Single requests are already one-hot; only the contended case needs a decision
   always_comb begin
      // NOTE: assign a default before any branch so the combinational block can never hold a value (no latch).
      grant = req;
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: grant, hold operands, capture, respond.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH      = 64,
   parameter int ALU_WAIT_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_arbiter_if.slave          bus,
   output logic [DATA_WIDTH-1:0] alu_A,
   output logic [DATA_WIDTH-1:0] alu_B,
   output logic [CNTRL_W-1:0]    alu_cntrl,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic [FLAG_W-1:0]     alu_flags
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(ALU_WAIT_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [WAIT_CNT_W-1:0]   wait_cnt_q;
   logic [DATA_WIDTH-1:0]   op_a_q, op_b_q, res_q;
   logic [CNTRL_W-1:0]      op_cntrl_q;
   logic [FLAG_W-1:0]       flags_q;
   logic                    grantee_q;
   logic                    last_q;
   logic [1:0]              grant;
   logic                    accept;
   logic                    cnt_zero;
   logic                    resp_hs;

   rr_arbiter2 u_rr (
      .req   (bus.req_valid),
      .last  (last_q),
      .grant (grant)
   );

   assign accept   = (state_q == IDLE) && (|bus.req_valid);
   assign cnt_zero = (wait_cnt_q == '0);
   // Only the grantee's resp_ready can complete the handshake
   assign resp_hs  = (state_q == DONE) && bus.resp_ready[grantee_q];

   // State register
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state: accept -> hold for ALU_WAIT_CYCLES -> present until handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)   state_d = EXEC;
         EXEC:    if (cnt_zero) state_d = DONE;
         DONE:    if (resp_hs)  state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   // Handshake outputs depend only on the current state and the live request lines
   always_comb begin
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      if (state_q == IDLE) bus.req_ready = grant;
      if (state_q == DONE) bus.resp_valid[grantee_q] = 1'b1;
   end

   // Operand latch on accept, countdown and result capture in EXEC, fairness bookkeeping on handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_cntrl_q <= '0;
         res_q      <= '0;
         flags_q    <= '0;
         grantee_q  <= 1'b0;
         last_q     <= 1'b1;
      end else begin
         if (accept) begin
            grantee_q  <= grant[1];
            op_a_q     <= bus.req_A[grant[1]];
            op_b_q     <= bus.req_B[grant[1]];
            op_cntrl_q <= bus.req_cntrl[grant[1]];
            wait_cnt_q <= WAIT_LOAD;
         end
         if (state_q == EXEC) begin
            if (cnt_zero) begin
               res_q   <= alu_result;
               flags_q <= alu_flags;
            end else begin
               wait_cnt_q <= wait_cnt_q - 1'b1;
            end
         end
         if (resp_hs) last_q <= grantee_q;
      end
   end

   assign alu_A           = op_a_q;
   assign alu_B           = op_b_q;
   assign alu_cntrl       = op_cntrl_q;
   assign bus.resp_result = res_q;
   assign bus.resp_flags  = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run against a cycle-count model.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int DW = 64;
   localparam int W4 = 4;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   // Environment ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, others a fixed scramble
   function automatic logic [67:0] alu_f(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
      logic [64:0] w;
      logic        ovf;
      ovf = 1'b0;
      case (op)
         3'd0: begin w = {1'b0, a} + {1'b0, b}; ovf = (a[63] == b[63]) && (w[63] != a[63]); end
         3'd1: begin w = {1'b0, a} - {1'b0, b}; ovf = (a[63] != b[63]) && (w[63] != a[63]); end
         3'd2: w = {1'b0, a & b};
         3'd3: w = {1'b0, a | b};
         3'd4: w = {1'b0, a ^ b};
         default: w = {1'b0, a ^ {b[31:0], b[63:32]}};
      endcase
      return {w[63], (w[63:0] == 64'd0), ovf, w[64], w[63:0]};
   endfunction

   // DUT with the default wait
   alu_arbiter_if #(.DATA_WIDTH(DW)) bus4 ();
   logic [DW-1:0] alu_a4, alu_b4, alu_res4;
   logic [2:0]    alu_cntrl4;
   logic [3:0]    alu_flags4;
   assign {alu_flags4, alu_res4} = alu_f(alu_a4, alu_b4, alu_cntrl4);

   alu_arbiter #(.DATA_WIDTH(DW), .ALU_WAIT_CYCLES(W4)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus4.slave),
      .alu_A      (alu_a4),
      .alu_B      (alu_b4),
      .alu_cntrl  (alu_cntrl4),
      .alu_result (alu_res4),
      .alu_flags  (alu_flags4)
   );

   // DUT with the minimum wait
   alu_arbiter_if #(.DATA_WIDTH(DW)) bus1 ();
   logic [DW-1:0] alu_a1, alu_b1, alu_res1;
   logic [2:0]    alu_cntrl1;
   logic [3:0]    alu_flags1;
   assign {alu_flags1, alu_res1} = alu_f(alu_a1, alu_b1, alu_cntrl1);

   alu_arbiter #(.DATA_WIDTH(DW), .ALU_WAIT_CYCLES(1)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus1.slave),
      .alu_A      (alu_a1),
      .alu_B      (alu_b1),
      .alu_cntrl  (alu_cntrl1),
      .alu_result (alu_res1),
      .alu_flags  (alu_flags1)
   );

   task automatic check(input string tag, input logic [67:0] act, input logic [67:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus4.req_valid = 2'b00; bus4.resp_ready = 2'b00;
      bus1.req_valid = 2'b00; bus1.resp_ready = 2'b00;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Model state for the randomized run
   bit          m_busy;
   int          m_g;
   int          m_due;
   int          m_last;
   logic [67:0] m_exp;
   logic [63:0] m_a;
   logic [2:0]  m_cntrl;

   initial begin
      bus4.req_A = '0; bus4.req_B = '0; bus4.req_cntrl = '0;
      bus1.req_A = '0; bus1.req_B = '0; bus1.req_cntrl = '0;
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();

      // Reset state
      check("rst_req_ready",  bus4.req_ready, 2'b00);
      check("rst_resp_valid", bus4.resp_valid, 2'b00);
      check("rst_alu_A",      alu_a4, 64'd0);
      check("rst_alu_B",      alu_b4, 64'd0);
      check("rst_alu_cntrl",  alu_cntrl4, 3'd0);
      check("rst_result",     bus4.resp_result, 64'd0);
      check("rst_flags",      bus4.resp_flags, 4'd0);
      reset = 1'b0;

      // Contention right after reset, then backpressure on requester 0
      bus4.req_A[0] = 64'd10; bus4.req_B[0] = 64'd20; bus4.req_cntrl[0] = 3'd0;
      bus4.req_A[1] = 64'd7;  bus4.req_B[1] = 64'd2;  bus4.req_cntrl[1] = 3'd1;
      bus4.req_valid = 2'b11;
      #1;
      check("cont_first_grant", bus4.req_ready, 2'b01);
      for (int k = 1; k <= W4; k++) begin
         tick();
         check("cont_exec_no_resp", bus4.resp_valid, 2'b00);
         check("cont_exec_no_ready", bus4.req_ready, 2'b00);
      end
      tick();
      for (int k = 0; k < 10; k++) begin
         check("bp_resp_valid", bus4.resp_valid, 2'b01);
         check("bp_result",     bus4.resp_result, 64'd30);
         check("bp_req_ready",  bus4.req_ready, 2'b00);
         tick();
      end
      bus4.resp_ready = 2'b01;
      #1;
      check("hs_no_same_cycle_accept", bus4.req_ready, 2'b00);
      tick();
      check("cont_second_grant", bus4.req_ready, 2'b10);
      bus4.resp_ready = 2'b00;
      tick();
      bus4.req_valid = 2'b00;
      repeat (W4) tick();
      check("r1_resp_valid", bus4.resp_valid, 2'b10);
      check("r1_result",     bus4.resp_result, 64'd5);
      bus4.resp_ready = 2'b01;
      tick();
      check("non_grantee_ready_ignored", bus4.resp_valid, 2'b10);
      bus4.resp_ready = 2'b10;
      tick();
      check("r1_after_hs", bus4.resp_valid, 2'b00);
      bus4.resp_ready = 2'b00;

      // Single request, add 5+3, operand hold while in EXEC
      do_reset();
      bus4.req_A[0] = 64'd5; bus4.req_B[0] = 64'd3; bus4.req_cntrl[0] = 3'd0;
      bus4.req_valid = 2'b01;
      #1;
      check("single_grant", bus4.req_ready, 2'b01);
      tick();
      bus4.req_valid = 2'b00;
      bus4.req_A[0] = 64'd99;
      check("single_alu_B", alu_b4, 64'd3);
      for (int k = 1; k <= W4; k++) begin
         check("hold_alu_A", alu_a4, 64'd5);
         check("single_no_early_resp", bus4.resp_valid, 2'b00);
         tick();
      end
      check("single_resp_valid", bus4.resp_valid, 2'b01);
      check("single_result",     bus4.resp_result, 64'd8);
      check("single_zero_flag",  bus4.resp_flags[FLAG_ZERO], 1'b0);
      bus4.resp_ready = 2'b01;
      tick();
      bus4.resp_ready = 2'b00;
      check("single_after_hs", bus4.resp_valid, 2'b00);
      check("hold_alu_A_idle", alu_a4, 64'd5);

      // Reset two cycles after an accept aborts the operation
      bus4.req_A[0] = 64'd123; bus4.req_valid = 2'b01;
      tick();
      bus4.req_valid = 2'b00;
      tick();
      reset = 1'b1;
      tick();
      check("abort_resp_valid", bus4.resp_valid, 2'b00);
      check("abort_alu_A",      alu_a4, 64'd0);
      reset = 1'b0;
      bus4.req_valid = 2'b11;
      #1;
      check("abort_idle_grant", bus4.req_ready, 2'b01);
      bus4.req_valid = 2'b00;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("abort_no_resp", bus4.resp_valid, 2'b00);
      end

      // Randomized run against the model
      do_reset();
      m_busy = 1'b0; m_last = 1; m_g = 0; m_due = 0; m_exp = '0; m_a = '0; m_cntrl = '0;
      for (int c = 0; c < 3000; c++) begin
         logic [1:0] rv, exp_rdy, exp_rv;
         bit         rst_now;
         int         win;
         rv = 2'($urandom_range(0, 3));
         rst_now = ($urandom_range(0, 149) == 0);
         reset = rst_now;
         for (int i = 0; i < 2; i++) begin
            bus4.req_A[i]     = {$urandom, $urandom};
            bus4.req_B[i]     = {$urandom, $urandom};
            bus4.req_cntrl[i] = 3'($urandom_range(0, 7));
         end
         bus4.req_valid  = rv;
         bus4.resp_ready = 2'($urandom_range(0, 3));
         #1;
         if (rv == 2'b11)      win = (m_last == 1) ? 0 : 1;
         else if (rv == 2'b10) win = 1;
         else                  win = 0;
         exp_rdy = (!m_busy && rv != 2'b00) ? 2'(1 << win) : 2'b00;
         exp_rv  = (m_busy && c >= m_due) ? 2'(1 << m_g) : 2'b00;
         check("rnd_req_ready",  bus4.req_ready, exp_rdy);
         check("rnd_resp_valid", bus4.resp_valid, exp_rv);
         if (exp_rv != 2'b00) begin
            check("rnd_result", {bus4.resp_flags, bus4.resp_result}, m_exp);
         end
         if (m_busy) begin
            check("rnd_alu_A",     alu_a4, m_a);
            check("rnd_alu_cntrl", alu_cntrl4, m_cntrl);
         end
         if (rst_now) begin
            m_busy = 1'b0;
            m_last = 1;
         end else if (!m_busy && rv != 2'b00) begin
            m_busy  = 1'b1;
            m_g     = win;
            m_due   = c + W4 + 1;
            m_a     = bus4.req_A[win];
            m_cntrl = bus4.req_cntrl[win];
            m_exp   = alu_f(bus4.req_A[win], bus4.req_B[win], bus4.req_cntrl[win]);
         end else if (m_busy && c >= m_due && bus4.resp_ready[m_g]) begin
            m_busy = 1'b0;
            m_last = m_g;
         end
         tick();
      end
      reset = 1'b0;

      // Minimum wait: and(0xFF, 0x0F)
      do_reset();
      bus1.req_A[0] = 64'hFF; bus1.req_B[0] = 64'h0F; bus1.req_cntrl[0] = 3'd2;
      bus1.req_valid = 2'b01;
      #1;
      check("w1_grant", bus1.req_ready, 2'b01);
      tick();
      bus1.req_valid = 2'b00;
      check("w1_no_early_resp", bus1.resp_valid, 2'b00);
      tick();
      check("w1_resp_valid", bus1.resp_valid, 2'b01);
      check("w1_result",     bus1.resp_result, 64'h0F);
      bus1.resp_ready = 2'b01;
      tick();
      bus1.resp_ready = 2'b00;
      check("w1_after_hs", bus1.resp_valid, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of operands and result.
REQ-002 Parameter ALU_WAIT_CYCLES, default 4, number of cycles operands are held stable on the shared ALU before the result is captured; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  request pending; bit i belongs to requester i.
REQ-006 req_ready  output  2  request accepted this cycle; bit i for requester i.
REQ-007 req_A  input  2xDATA_WIDTH  first operand; slice i for requester i.
REQ-008 req_B  input  2xDATA_WIDTH  second operand; slice i for requester i.
REQ-009 req_cntrl  input  2x3  ALU operation code; slice i for requester i.
REQ-010 resp_valid  output  2  result available for requester i.
REQ-011 resp_ready  input  2  requester i consumes the result.
REQ-012 resp_result  output  DATA_WIDTH  captured ALU result.
REQ-013 resp_flags  output  4  captured {negative, zero, overflow, carry_out}.
REQ-014 alu_A, alu_B  output  DATA_WIDTH each  operands driven to the shared ALU.
REQ-015 alu_cntrl  output  3  operation code driven to the shared ALU.
REQ-016 alu_result  input  DATA_WIDTH  ALU result.
REQ-017 alu_flags  input  4  ALU {negative, zero, overflow, carry_out}.

Function
REQ-018 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-019 In IDLE with any req_valid high, the block SHALL assert req_ready for exactly one requester, the grantee, in the same cycle; req_ready is combinational from req_valid and state only.
REQ-020 Grant SHALL be round-robin: when both requesters are valid, the requester not granted last wins.
REQ-021 On the accept edge, the block SHALL latch the grantee's A, B and cntrl, load wait_cnt with ALU_WAIT_CYCLES-1, and enter EXEC.
REQ-022 alu_A, alu_B and alu_cntrl SHALL always equal the latched operand registers, which change only on an accept edge.
REQ-023 In EXEC, wait_cnt SHALL decrement each cycle. When wait_cnt==0, the block SHALL capture alu_result and alu_flags into the response registers and enter DONE.
REQ-024 Latency: if the accept occurs in cycle T, resp_valid[grantee] SHALL first be high in cycle T+ALU_WAIT_CYCLES+1.
REQ-025 In DONE, resp_valid SHALL be high only for the grantee; resp_result and resp_flags SHALL be stable until the handshake.
REQ-026 When resp_valid[g] and resp_ready[g] are both high, the block SHALL record g as last-granted and return to IDLE. No new accept may occur in that same cycle.
REQ-027 req_ready SHALL be 0 in EXEC and DONE; requests are not accepted while the block is busy.
REQ-028 resp_ready for the non-grantee SHALL be ignored.
REQ-029 cntrl codes SHALL be forwarded unmodified, including undefined codes; the block does not decode them.
REQ-030 A requester dropping req_valid while not granted SHALL have no effect.

Reset
REQ-031 While reset is high at a clock edge, the block SHALL enter IDLE and clear wait_cnt, operand registers, response registers, req_ready and resp_valid to 0.
REQ-032 After reset, last-granted SHALL be 1, so requester 0 wins the first contended grant.
REQ-033 Reset asserted in EXEC or DONE SHALL abort the operation and produce no response.

Structure
REQ-034 State enum (IDLE, EXEC, DONE), the flag bit indices and the 3-bit ALU cntrl width constant SHALL reside in a shared package, alu_pkg.
REQ-035 Grant selection SHALL be a sub-module, rr_arbiter2, with inputs req[1:0] and last[0] and output one-hot grant[1:0].
REQ-036 The shared ALU SHALL be instantiated outside this block.

Verification
REQ-037 Single request: A=5, B=3, cntrl=add to requester 0, ALU_WAIT_CYCLES=4, accept at T → resp_valid[0] high at T+5, resp_result=8, zero flag=0.
REQ-038 Contention after reset: both requesters valid in the same cycle → req_ready=01. After requester 0's response handshake with both still valid → req_ready=10.
REQ-039 Backpressure: resp_ready[0] held low for 10 cycles → resp_valid[0] stays high, result stable, req_ready=00 throughout, and one cycle after handshake req_ready reflects the next grant.
REQ-040 Operand hold: change req_A[0] during EXEC → alu_A unchanged until the next accept.
REQ-041 Reset mid-EXEC: reset in cycle T+2 → resp_valid=00, state IDLE, alu_A=0 at T+3, no response ever issued for that request.
REQ-042 ALU_WAIT_CYCLES=1 with and (0xFF, 0x0F) → resp_valid at T+2, result 0x0F.
